// File: rtl/mat_pkg.sv
// Shared types for the systolic matrix engine A/B buffer generators.
// Bank indexing and dimension widths are common to write and read sides.
package mat_pkg;

    localparam int NUM_BANKS = 2;
    localparam int DIM_W     = 16;

    typedef logic             bank_t;
    typedef logic [DIM_W-1:0] dim_t;

endpackage

// File: rtl/mem_bank_flags.sv
// Per-bank full flags exchanged with the buffer reader.
// A set and a release on the same bank in one cycle resolves to set.
module mem_bank_flags
    import mat_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 set_i,
    input  bank_t                set_bank_i,
    input  logic [NUM_BANKS-1:0] release_i,
    output logic [NUM_BANKS-1:0] full_o
);

    logic [NUM_BANKS-1:0] full_q;
    logic [NUM_BANKS-1:0] full_d;

    always_comb begin
        full_d = full_q & ~release_i;
        if (set_i) begin
            full_d[set_bank_i] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= '0;
        end else begin
            full_q <= full_d;
        end
    end

    assign full_o = full_q;

endmodule

// File: rtl/mem_write_a_res.sv
// A-operand buffer write address generator: linear phase*M2+col order,
// ping-ponging between two banks with full/release handshake to the reader.
module mem_write_a_res
    import mat_pkg::*;
#(
    parameter int N1           = 4,
    parameter int MATRIXSIZE_W = 16,
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [MATRIXSIZE_W-1:0] M2,
    input  logic [MATRIXSIZE_W-1:0] M1dN1,
    input  logic                    in_valid,
    input  logic [DATA_W-1:0]       in_data,
    output logic                    in_ready,
    output logic                    wr_en_A,
    output logic [ADDR_W-1:0]       wr_addr_A,
    output logic [DATA_W-1:0]       wr_data_A,
    output logic                    wr_bank_A,
    output logic                    last_addr_A,
    output logic [1:0]              buf_full,
    input  logic [1:0]              buf_release
);

    localparam logic [MATRIXSIZE_W-1:0] ONE = 1;

    if (N1 < 1 || ADDR_W > MATRIXSIZE_W) begin : g_bad_params
        $error("mem_write_a_res: illegal parameterisation");
    end

    logic [MATRIXSIZE_W-1:0] col_q, col_d;
    logic [MATRIXSIZE_W-1:0] phase_q, phase_d;
    logic [MATRIXSIZE_W-1:0] offset_q, offset_d;
    bank_t                   wb_q, wb_d;
    logic                    pend_q, pend_d;
    bank_t                   pbank_q, pbank_d;

    logic                    wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [DATA_W-1:0]       data_q, data_d;
    bank_t                   bank_q, bank_d;
    logic                    last_q, last_d;

    logic [1:0]              full;
    logic                    accept;
    logic                    col_end;
    logic                    bank_end;

    assign in_ready = !full[wb_q];
    assign accept   = in_valid && in_ready;
    assign col_end  = (col_q == M2 - ONE);
    assign bank_end = col_end && (phase_q == M1dN1 - ONE);

    always_comb begin
        col_d    = col_q;
        phase_d  = phase_q;
        offset_d = offset_q;
        wb_d     = wb_q;
        pend_d   = 1'b0;
        pbank_d  = pbank_q;
        wr_en_d  = 1'b0;
        last_d   = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        bank_d   = bank_q;
        if (accept) begin
            wr_en_d = 1'b1;
            addr_d  = ADDR_W'(col_q + offset_q);
            data_d  = in_data;
            bank_d  = wb_q;
            col_d   = col_q + ONE;
            if (col_end) begin
                col_d    = '0;
                offset_d = offset_q + M2;
                phase_d  = phase_q + ONE;
            end
            // Bank wrap: flag the old bank one cycle after its last write lands
            if (bank_end) begin
                last_d   = 1'b1;
                offset_d = '0;
                phase_d  = '0;
                wb_d     = !wb_q;
                pend_d   = 1'b1;
                pbank_d  = wb_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q    <= '0;
            phase_q  <= '0;
            offset_q <= '0;
            wb_q     <= 1'b0;
            pend_q   <= 1'b0;
            pbank_q  <= 1'b0;
            wr_en_q  <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            bank_q   <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            col_q    <= col_d;
            phase_q  <= phase_d;
            offset_q <= offset_d;
            wb_q     <= wb_d;
            pend_q   <= pend_d;
            pbank_q  <= pbank_d;
            wr_en_q  <= wr_en_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            bank_q   <= bank_d;
            last_q   <= last_d;
        end
    end

    mem_bank_flags u_flags (
        .clk        (clk),
        .rst        (rst),
        .set_i      (pend_q),
        .set_bank_i (pbank_q),
        .release_i  (buf_release),
        .full_o     (full)
    );

    assign wr_en_A     = wr_en_q;
    assign wr_addr_A   = addr_q;
    assign wr_data_A   = data_q;
    assign wr_bank_A   = bank_q;
    assign last_addr_A = last_q;
    assign buf_full    = full;

endmodule

// File: tb/tb_mem_write_a_res.sv
// Randomized self-checking bench for mem_write_a_res against a
// word-count based reference model of the A buffer fill order.
module tb_mem_write_a_res;

    localparam int MW = 16;
    localparam int AW = 12;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [MW-1:0] M2;
    logic [MW-1:0] M1dN1;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          wr_en_A;
    logic [AW-1:0] wr_addr_A;
    logic [DW-1:0] wr_data_A;
    logic          wr_bank_A;
    logic          last_addr_A;
    logic [1:0]    buf_full;
    logic [1:0]    buf_release;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int       k;
    int       mwb;
    bit [1:0] mfull;
    bit       mpend;
    int       mpbank;
    bit       e_en;
    int       e_addr;
    bit [DW-1:0] e_data;
    int       e_bank;
    bit       e_last;

    mem_write_a_res dut (
        .clk         (clk),
        .rst         (rst),
        .M2          (M2),
        .M1dN1       (M1dN1),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .wr_en_A     (wr_en_A),
        .wr_addr_A   (wr_addr_A),
        .wr_data_A   (wr_data_A),
        .wr_bank_A   (wr_bank_A),
        .last_addr_A (last_addr_A),
        .buf_full    (buf_full),
        .buf_release (buf_release)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        k = 0; mwb = 0; mfull = 2'b00; mpend = 0; mpbank = 0;
        e_en = 0; e_addr = 0; e_data = '0; e_bank = 0; e_last = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".en"},   64'(wr_en_A),     64'(e_en));
        chk({tag, ".last"}, 64'(last_addr_A), 64'(e_last));
        chk({tag, ".addr"}, 64'(wr_addr_A),   64'(e_addr));
        chk({tag, ".data"}, 64'(wr_data_A),   64'(e_data));
        chk({tag, ".bank"}, 64'(wr_bank_A),   64'(e_bank));
        chk({tag, ".full"}, 64'(buf_full),    64'(mfull));
    endtask

    // Called at the negedge: drive, check ready, clock, update model, check.
    task automatic step(input bit v, input bit [DW-1:0] d,
                        input bit [1:0] rel, input string tag);
        bit rdy, acc, pp;
        int pb, tot;
        in_valid = v; in_data = d; buf_release = rel;
        #1;
        rdy = !mfull[mwb];
        chk({tag, ".ready"}, 64'(in_ready), 64'(rdy));
        acc = v && rdy;
        tot = int'(M2) * int'(M1dN1);
        pp = mpend; pb = mpbank;
        mpend = 0;
        e_en = acc; e_last = 0;
        if (acc) begin
            e_addr = k % (1 << AW);
            e_data = d;
            e_bank = mwb;
            k++;
            if (k == tot) begin
                e_last = 1; k = 0;
                mpend = 1; mpbank = mwb;
                mwb = 1 - mwb;
            end
        end
        for (int b = 0; b < 2; b++) if (rel[b]) mfull[b] = 0;
        if (pp) mfull[pb] = 1;
        @(posedge clk);
        #1;
        check_outputs(tag);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs("rst");
        chk("rst.ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        in_valid = 0; in_data = '0; buf_release = 2'b00;
        M2 = 16'd3; M1dN1 = 16'd2;
        @(negedge clk);
        do_reset();

        // two full banks back to back, then stall
        for (int i = 0; i < 14; i++) step(1, $urandom, 2'b00, "fill");
        chk("both_full", 64'(buf_full), 64'd3);
        step(1, $urandom, 2'b01, "rel0");
        for (int i = 0; i < 3; i++) step(1, $urandom, 2'b00, "resume");

        // single-word banks alternate, stall after two
        M2 = 16'd1; M1dN1 = 16'd1;
        do_reset();
        for (int i = 0; i < 4; i++) step(1, $urandom, 2'b00, "m1");
        step(1, $urandom, 2'b01, "m1rel");
        for (int i = 0; i < 2; i++) step(1, $urandom, 2'b00, "m1w3");

        // stray release on empty bank, and release colliding with set
        do_reset();
        step(0, '0, 2'b10, "stray");
        step(1, $urandom, 2'b00, "col_w");
        step(0, '0, 2'b01, "collide");
        step(0, '0, 2'b00, "col_after");
        chk("set_wins", 64'(buf_full), 64'd1);

        // randomized gaps and releases
        M2 = 16'd4; M1dN1 = 16'd3;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            bit [1:0] r;
            r = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
            step($urandom_range(0, 3) != 0, $urandom, r, "rand");
        end

        // async reset mid-bank
        do_reset();
        for (int i = 0; i < 5; i++) step(1, $urandom, 2'b00, "pre");
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs("async");
        chk("async.ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) step(1, $urandom, 2'b00, "post");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
